sum_mult_arbiter: RTL

SUM_MULT_ARBITER -- requirements
Module: sum_mult_arbiter

---
 rtl/sum_mult_arb_pkg.sv | 27 ++
 rtl/sum_mult_arbiter_if.sv | 35 +++
 rtl/sum_mult_arbiter_rr_arbiter2.sv | 45 ++++
 rtl/sum_mult_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/sum_mult_arb_pkg.sv
// ============================================================================
// Module   : sum_mult_arb_pkg
// Purpose  : Shared widths, opcodes and FSM state type for sum_mult_arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package sum_mult_arb_pkg;

   localparam int   DATA_W  = 16;
   localparam int   CNT_W   = 4;
   localparam logic OP_SUM  = 1'b0;
   localparam logic OP_MULT = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   function automatic logic [1:0] idx_to_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage : sum_mult_arb_pkg

`default_nettype wire

// File: rtl/sum_mult_arbiter_if.sv
// ============================================================================
// Module   : sum_mult_arbiter_if
// Purpose  : Request/response bundle between two requesters and the arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface sum_mult_arbiter_if;
   import sum_mult_arb_pkg::*;

   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic [1:0]        req_op;
   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_id;
   logic [DATA_W-1:0] rsp_data;

   modport master (
      output req_valid, req0_a, req0_b, req1_a, req1_b, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data
   );

   modport slave (
      input  req_valid, req0_a, req0_b, req1_a, req1_b, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data
   );

endinterface : sum_mult_arbiter_if

`default_nettype wire

// File: rtl/sum_mult_arbiter_rr_arbiter2.sv
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-way round-robin grant with a registered priority pointer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter2
   import sum_mult_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant,
   output logic       grant_idx
);

   // prio_q names the requester that wins a tie; 0 out of reset
   logic prio_q;
   logic prio_d;

   always_comb begin
      grant_idx = 1'b0;
      case (req)
         2'b01:   grant_idx = 1'b0;
         2'b10:   grant_idx = 1'b1;
         2'b11:   grant_idx = prio_q;
         default: grant_idx = 1'b0;
      endcase
      grant  = (req == 2'b00) ? 2'b00 : idx_to_onehot(grant_idx);
      prio_d = advance ? ~grant_idx : prio_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule : rr_arbiter2

`default_nettype wire

// File: rtl/sum_mult_arbiter.sv
// ============================================================================
// Module   : sum_mult_arbiter
// Purpose  : Arbitrates two requesters onto one shared sum/multiply unit.
//            Optional per-requester grant counters: SUM_MULT_ARB_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sum_mult_arbiter
   import sum_mult_arb_pkg::*;
#(
   parameter int ALU_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   sum_mult_arbiter_if.slave bus,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic              alu_op,
   input  logic [DATA_W-1:0] alu_out,
   output logic              busy
`ifdef SUM_MULT_ARB_STATS_EN
   ,
   output logic [DATA_W-1:0] grant_cnt0,
   output logic [DATA_W-1:0] grant_cnt1
`endif
);

   state_e            state_q,     state_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;
   logic [DATA_W-1:0] alu_a_q,     alu_a_d;
   logic [DATA_W-1:0] alu_b_q,     alu_b_d;
   logic              alu_op_q,    alu_op_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_id_q,    rsp_id_d;
   logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
   logic              busy_q,      busy_d;

   logic [1:0] grant;
   logic       grant_idx;
   logic       hs;

   assign hs = (state_q == IDLE) && (bus.req_valid != 2'b00);

   rr_arbiter2 u_rr_arbiter2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (bus.req_valid),
      .advance   (hs),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      busy_d      = busy_q;
      case (state_q)
         IDLE: begin
            if (hs) begin
               alu_a_d  = grant_idx ? bus.req1_a : bus.req0_a;
               alu_b_d  = grant_idx ? bus.req1_b : bus.req0_b;
               alu_op_d = bus.req_op[grant_idx];
               rsp_id_d = grant_idx;
               cnt_d    = CNT_W'(ALU_LATENCY);
               state_d  = WAIT;
               busy_d   = 1'b1;
            end
         end
         WAIT: begin
            // Counter runs out one edge after the unit's latency so the
            // capture sees the result the unit produced on that last edge.
            if (cnt_q == '0) begin
               rsp_data_d  = alu_out;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               busy_d      = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.req_ready = (state_q == IDLE) ? grant : 2'b00;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign alu_a         = alu_a_q;
   assign alu_b         = alu_b_q;
   assign alu_op        = alu_op_q;
   assign busy          = busy_q;

`ifdef SUM_MULT_ARB_STATS_EN
   logic [DATA_W-1:0] grant_cnt0_q, grant_cnt0_d;
   logic [DATA_W-1:0] grant_cnt1_q, grant_cnt1_d;

   always_comb begin
      grant_cnt0_d = grant_cnt0_q;
      grant_cnt1_d = grant_cnt1_q;
      if (hs && !grant_idx && (grant_cnt0_q != '1)) begin
         grant_cnt0_d = grant_cnt0_q + 1'b1;
      end
      if (hs && grant_idx && (grant_cnt1_q != '1)) begin
         grant_cnt1_d = grant_cnt1_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt0_q <= '0;
         grant_cnt1_q <= '0;
      end else begin
         grant_cnt0_q <= grant_cnt0_d;
         grant_cnt1_q <= grant_cnt1_d;
      end
   end

   assign grant_cnt0 = grant_cnt0_q;
   assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule : sum_mult_arbiter

`default_nettype wire
